// File: rtl/ifetch_sequencer_if.sv
// ---------------------------------------------------------------------------
// ifetch_sequencer_if
//   Bundles the instruction-ROM bus, the execute redirect port and the
//   decode valid/ready handshake of the instruction-fetch sequencer.
//
//   Signals:
//     fetch_en        1   fetching allowed
//     imem_address   32   ROM byte address (driven by the sequencer)
//     imem_readdata  32   ROM word at imem_address, same cycle
//     redirect_valid  1   one-cycle flush/restart pulse from execute
//     redirect_pc    32   restart address
//     instr_valid     1   instruction available to decode
//     instr_ready     1   decode accepts the head instruction
//     instr_data     32   head instruction word (0 when empty)
//     instr_pc       32   PC of the head instruction (0 when empty)
//     fetch_misalign  1   sticky misaligned-redirect flag
//
//   Modports:
//     master  - the fetch sequencer
//     slave   - the surrounding core / ROM / decode side
// ---------------------------------------------------------------------------
interface ifetch_sequencer_if;
    logic        fetch_en;
    logic [31:0] imem_address;
    logic [31:0] imem_readdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        fetch_misalign;

    modport master (
        input  fetch_en,
        input  imem_readdata,
        input  redirect_valid,
        input  redirect_pc,
        input  instr_ready,
        output imem_address,
        output instr_valid,
        output instr_data,
        output instr_pc,
        output fetch_misalign
    );

    modport slave (
        output fetch_en,
        output imem_readdata,
        output redirect_valid,
        output redirect_pc,
        output instr_ready,
        input  imem_address,
        input  instr_valid,
        input  instr_data,
        input  instr_pc,
        input  fetch_misalign
    );
endinterface

// File: rtl/ifetch_sequencer.sv
// ---------------------------------------------------------------------------
// ifetch_sequencer
//   Instruction-fetch controller for a Harvard instruction ROM with a
//   combinational 32-bit read port. Owns the fetch PC, drives the ROM
//   address from the PC register, captures {pc, word} into a small prefetch
//   FIFO and hands instructions to decode over valid/ready. Execute can
//   flush and restart fetch with a one-cycle redirect pulse.
//
//   Parameters:
//     RESET_PC    PC loaded on reset (word aligned)
//     FIFO_DEPTH  prefetch entries (power of two, >= 2)
//
//   Ports:
//     clk    in  rising-edge clock
//     rst_n  in  asynchronous active-low reset
//     bus    ifetch_sequencer_if.master (ROM bus, redirect, decode handshake)
//
//   Build option:
//     IFETCH_ALIGN_CHECK_EN  when defined, a redirect to a non word-aligned
//                            address flushes, parks the sequencer in ERR and
//                            sets the sticky fetch_misalign flag; otherwise
//                            the low two address bits are silently cleared.
// ---------------------------------------------------------------------------
module ifetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    ifetch_sequencer_if.master bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        STALL
`ifdef IFETCH_ALIGN_CHECK_EN
        , ERR
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        fifo_pc_q   [FIFO_DEPTH];
    logic [31:0]        fifo_data_q [FIFO_DEPTH];

    logic               redirect_take;
    logic               pop;
    logic               push;
    logic               fifo_full;
    logic               instr_valid;

`ifdef IFETCH_ALIGN_CHECK_EN
    logic               misalign_q, misalign_d;
    logic               redirect_bad;

    // Redirects are ignored once parked in ERR.
    assign redirect_take = bus.redirect_valid && (state_q != ERR);
    assign redirect_bad  = bus.redirect_pc[1:0] != 2'b00;
    assign bus.fetch_misalign = misalign_q;
`else
    assign redirect_take = bus.redirect_valid;
    assign bus.fetch_misalign = 1'b0;
`endif

    assign fifo_full   = (count_q == DEPTH_C);
    assign instr_valid = (count_q != '0);
    assign pop         = instr_valid && bus.instr_ready;

    // A full FIFO can still accept a word when decode drains one the same cycle.
    assign push = (state_q == FETCH) && bus.fetch_en && !redirect_take &&
                  (!fifo_full || pop);

    assign bus.imem_address = pc_q;
    assign bus.instr_valid  = instr_valid;
    assign bus.instr_data   = instr_valid ? fifo_data_q[rd_ptr_q] : 32'h0;
    assign bus.instr_pc     = instr_valid ? fifo_pc_q[rd_ptr_q]   : 32'h0;

    // Next-state logic: FSM transitions, FIFO bookkeeping, then redirect
    // overriding everything because it has the highest priority.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
`ifdef IFETCH_ALIGN_CHECK_EN
        misalign_d = misalign_q;
`endif

        case (state_q)
            IDLE:    if (bus.fetch_en) state_d = FETCH;
            FETCH: begin
                if (!bus.fetch_en)          state_d = IDLE;
                else if (fifo_full && !pop) state_d = STALL;
            end
            STALL:   if (pop) state_d = FETCH;
`ifdef IFETCH_ALIGN_CHECK_EN
            ERR:     state_d = ERR;
`endif
            default: state_d = IDLE;
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            pc_d     = pc_q + 32'd4;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // A coincident pop has already been seen by decode; the rest is dropped.
        if (redirect_take) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            pc_d     = bus.redirect_pc & 32'hFFFF_FFFC;
            state_d  = bus.fetch_en ? FETCH : IDLE;
`ifdef IFETCH_ALIGN_CHECK_EN
            if (redirect_bad) begin
                pc_d       = bus.redirect_pc;
                state_d    = ERR;
                misalign_d = 1'b1;
            end
`endif
        end
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef IFETCH_ALIGN_CHECK_EN
    // Sticky misalignment flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign_q <= 1'b0;
        else        misalign_q <= misalign_d;
    end
`endif

    // Prefetch storage: each entry holds the word and the PC it came from.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc_q[i]   <= 32'h0;
                fifo_data_q[i] <= 32'h0;
            end
        end else if (push) begin
            fifo_pc_q[wr_ptr_q]   <= pc_q;
            fifo_data_q[wr_ptr_q] <= bus.imem_readdata;
        end
    end

endmodule

// File: tb/tb_ifetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ifetch_sequencer
//   Directed bench for ifetch_sequencer: a per-cycle vector table covering
//   startup latency, back-pressure/stall, redirect flush and fetch_en
//   gating, followed by hand-written sequences for address wrap-around,
//   asynchronous reset mid-stream and misaligned redirects.
//   Inputs change on the falling edge; outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_ifetch_sequencer;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    ifetch_sequencer_if bus ();

    ifetch_sequencer #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        fetchEn;
        logic        ready;
        logic        redirValid;
        logic [31:0] redirPc;
        logic        expValid;
        logic [31:0] expPc;
        logic [31:0] expData;
        logic [31:0] expAddr;
    } vec_t;

    vec_t vecs [20];

    // ROM contents: two fixed words at 0 and 4, an address-tagged pattern elsewhere.
    function automatic logic [31:0] romWord(input logic [31:0] addr);
        if (addr == 32'h0)      return 32'h0020_0008;
        else if (addr == 32'h4) return 32'h0000_0000;
        else                    return addr ^ 32'hDEAD_0000;
    endfunction

    assign bus.imem_readdata = romWord(bus.imem_address);

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic rdy,
                                 input logic rv, input logic [31:0] rpc);
        bus.fetch_en       = en;
        bus.instr_ready    = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
    endtask

    // Main sequence.
    initial begin
        bit got;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);

        vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0,         32'h0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0,         32'h0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h0,  32'h0020_0008, 32'h4};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h4,  32'h0,         32'h8};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h4,  32'h0,         32'hC};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h4,  32'h0,         32'hC};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h4,  32'h0,         32'hC};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h4,  32'h0,         32'hC};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h4,  32'h0,         32'hC};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h8,  32'hDEAD_0008, 32'hC};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'hC,  32'hDEAD_000C, 32'h10};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 32'h40, 1'b1, 32'hC,  32'hDEAD_000C, 32'h14};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0,         32'h40};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h40, 32'hDEAD_0040, 32'h44};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h44, 32'hDEAD_0044, 32'h48};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h44, 32'hDEAD_0044, 32'h48};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0,         32'h48};
        vecs[17] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0,         32'h48};
        vecs[18] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0,         32'h48};
        vecs[19] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h48, 32'hDEAD_0048, 32'h4C};

        // Reset values while held in reset.
        @(negedge clk);
        #1;
        checkOutput("reset_valid",    32'(bus.instr_valid),    32'h0);
        checkOutput("reset_data",     bus.instr_data,          32'h0);
        checkOutput("reset_pc",       bus.instr_pc,            32'h0);
        checkOutput("reset_addr",     bus.imem_address,        32'h0);
        checkOutput("reset_misalign", 32'(bus.fetch_misalign), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Per-cycle vector table.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i].fetchEn, vecs[i].ready, vecs[i].redirValid, vecs[i].redirPc);
            #1;
            checkOutput($sformatf("vec%0d_valid", i), 32'(bus.instr_valid), 32'(vecs[i].expValid));
            checkOutput($sformatf("vec%0d_pc", i),    bus.instr_pc,         vecs[i].expPc);
            checkOutput($sformatf("vec%0d_data", i),  bus.instr_data,       vecs[i].expData);
            checkOutput($sformatf("vec%0d_addr", i),  bus.imem_address,     vecs[i].expAddr);
        end

        // Redirect to the last word of the address space: PC wraps to 0.
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        #1;
        checkOutput("wrap_flush_valid", 32'(bus.instr_valid), 32'h0);
        checkOutput("wrap_addr",        bus.imem_address,     32'hFFFF_FFFC);
        @(negedge clk);
        #1;
        checkOutput("wrap_first_pc",   bus.instr_pc,   32'hFFFF_FFFC);
        checkOutput("wrap_first_data", bus.instr_data, 32'h2152_FFFC);
        @(negedge clk);
        #1;
        checkOutput("wrap_second_pc",   bus.instr_pc,   32'h0);
        checkOutput("wrap_second_data", bus.instr_data, 32'h0020_0008);

        // Asynchronous reset asserted between clock edges.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", 32'(bus.instr_valid), 32'h0);
        checkOutput("async_rst_pc",    bus.instr_pc,         32'h0);
        checkOutput("async_rst_data",  bus.instr_data,       32'h0);
        checkOutput("async_rst_addr",  bus.imem_address,     32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Restart from RESET_PC within a bounded number of cycles.
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (bus.instr_valid) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput("restart_seen", 32'(got),       32'h1);
        checkOutput("restart_pc",   bus.instr_pc,   32'h0);
        checkOutput("restart_data", bus.instr_data, 32'h0020_0008);
        @(negedge clk);
        #1;
        checkOutput("restart_next_pc",   bus.instr_pc,   32'h4);
        checkOutput("restart_next_data", bus.instr_data, 32'h0);

        // Misaligned redirect to 0x42, then an ordinary redirect to 0x80.
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h42);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        #1;
        checkOutput("mis_flush_valid", 32'(bus.instr_valid), 32'h0);
        @(negedge clk);
        #1;
`ifdef IFETCH_ALIGN_CHECK_EN
        checkOutput("mis_err_valid", 32'(bus.instr_valid),    32'h0);
        checkOutput("mis_flag",      32'(bus.fetch_misalign), 32'h1);
        checkOutput("mis_err_addr",  bus.imem_address,        32'h42);
`else
        checkOutput("mis_valid",    32'(bus.instr_valid),    32'h1);
        checkOutput("mis_pc",       bus.instr_pc,            32'h40);
        checkOutput("mis_data",     bus.instr_data,          32'hDEAD_0040);
        checkOutput("mis_no_flag",  32'(bus.fetch_misalign), 32'h0);
`endif
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h80);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        #1;
`ifdef IFETCH_ALIGN_CHECK_EN
        checkOutput("err_hold_valid", 32'(bus.instr_valid),    32'h0);
        checkOutput("err_hold_flag",  32'(bus.fetch_misalign), 32'h1);
        checkOutput("err_hold_addr",  bus.imem_address,        32'h42);
`else
        checkOutput("redir80_valid", 32'(bus.instr_valid), 32'h1);
        checkOutput("redir80_pc",    bus.instr_pc,         32'h80);
        checkOutput("redir80_data",  bus.instr_data,       32'hDEAD_0080);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation timed out");
    end

endmodule
